// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle scheduler: slot count, slot one-hot
// codes, FSM state encoding and a slot-decode helper.
package obstacle_pkg;

  localparam int N_OBST = 4;
  localparam int PIX_W  = 12;
  localparam int CNT_W  = 30;

  // Slot one-hot codes; slot 1 drives the horizontal lasers.
  localparam logic [3:0] SLOT_0 = 4'b0001;
  localparam logic [3:0] SLOT_1 = 4'b0010;
  localparam logic [3:0] SLOT_2 = 4'b0100;
  localparam logic [3:0] SLOT_3 = 4'b1000;

  // FSM state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PICK  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Slot index to one-hot select code.
  function automatic logic [3:0] slot_code(input logic [1:0] idx);
    logic [3:0] code;
    case (idx)
      2'd0:    code = SLOT_0;
      2'd1:    code = SLOT_1;
      2'd2:    code = SLOT_2;
      default: code = SLOT_3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advancing when en=1.
// Exposes the low two bits of the value it is about to load, so the caller
// can register a slot choice on the same edge the LFSR steps.
module obstacle_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] pick_bits
);

  logic [7:0] lfsr_reg;
  logic [7:0] lfsr_next;

  // Shift left, feedback from taps 8,6,5,4 (bits 7,5,4,3).
  always_comb begin
    lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  end

  // LFSR register; the seed must be non-zero or the sequence locks up.
  always_ff @(posedge pclk) begin
    if (rst) lfsr_reg <= SEED;
    else if (en) lfsr_reg <= lfsr_next;
  end

  assign pick_bits = lfsr_next[1:0];

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle sequencer: picks a slot pseudo-randomly, pulses start, waits for
// the slot's done (or the watchdog), rests for a gap and repeats for a fixed
// number of rounds. Also muxes the active slot's pixel and hit coordinates.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int         N_ROUNDS       = 8,
  parameter int         GAP_CYCLES     = 32000000,
  parameter int         TIMEOUT_CYCLES = (1 << 30) - 1,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        game_on,
  input  logic        menu_on,
  input  logic        play_selected,
  input  logic [3:0]  obst_done,
  input  logic [47:0] obst_rgb,
  input  logic [47:0] obst_x,
  input  logic [47:0] obst_y,
  input  logic [11:0] rgb_in,
  output logic [3:0]  selected,
  output logic        start,
  output logic [11:0] rgb_out,
  output logic [11:0] obstacle_x,
  output logic [11:0] obstacle_y,
  output logic [3:0]  round_cnt,
  output logic        all_done,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       ROUNDS   = 4'(N_ROUNDS);

  logic [2:0]       state_reg, state_next;
  logic [1:0]       index_reg, index_next;
  logic             have_prev_reg;
  logic [CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic [3:0]       selected_reg, selected_next;
  logic             start_reg, start_next;
  logic [3:0]       round_cnt_reg, round_cnt_next;
  logic             all_done_reg, all_done_next;
  logic             timeout_err_reg, timeout_err_next;
  logic [PIX_W-1:0] rgb_reg, rgb_next;
  logic [PIX_W-1:0] x_reg, x_next;
  logic [PIX_W-1:0] y_reg, y_next;
  logic [1:0]       lfsr_pick;
  logic             abort, run_done, wd_fire, gap_end;

  logic [PIX_W-1:0] slot_rgb [N_OBST];
  logic [PIX_W-1:0] slot_x   [N_OBST];
  logic [PIX_W-1:0] slot_y   [N_OBST];

  genvar gi;
  generate
    for (gi = 0; gi < N_OBST; gi++) begin : g_slot
      assign slot_rgb[gi] = obst_rgb[gi*PIX_W +: PIX_W];
      assign slot_x[gi]   = obst_x[gi*PIX_W +: PIX_W];
      assign slot_y[gi]   = obst_y[gi*PIX_W +: PIX_W];
    end
  endgenerate

  obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .pclk      (pclk),
    .rst       (rst),
    .en        (state_reg == ST_PICK),
    .pick_bits (lfsr_pick)
  );

  assign abort    = (state_reg != ST_IDLE) && (menu_on || !play_selected);
  assign run_done = obst_done[index_reg];
  assign wd_fire  = (wd_cnt_reg == WD_LAST);
  assign gap_end  = (gap_cnt_reg == GAP_LAST);

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) state_reg <= ST_IDLE;
    else state_reg <= state_next;
  end

  // Next-state logic; abort wins over any done/timeout in the same cycle.
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (game_on && play_selected && !menu_on) state_next = ST_PICK;
        ST_PICK:  state_next = ST_START;
        ST_START: state_next = ST_RUN;
        ST_RUN:   if (run_done || wd_fire) state_next = ST_GAP;
        ST_GAP:   if (gap_end) state_next = (round_cnt_reg == ROUNDS) ? ST_IDLE : ST_PICK;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Output/datapath next values; everything below is registered.
  always_comb begin
    index_next = index_reg;
    if (state_reg == ST_PICK) begin
      // Never repeat the slot that ran last.
      index_next = (have_prev_reg && lfsr_pick == index_reg) ? lfsr_pick + 2'd1 : lfsr_pick;
    end
    selected_next = (state_next == ST_START || state_next == ST_RUN) ? slot_code(index_next) : 4'b0000;
    start_next    = (state_reg == ST_START) && (state_next == ST_RUN);
    all_done_next = (state_reg == ST_GAP) && (state_next == ST_IDLE) && !abort;

    round_cnt_next = round_cnt_reg;
    if (state_reg == ST_IDLE) round_cnt_next = 4'd0;
    else if (state_reg == ST_RUN && state_next == ST_GAP && round_cnt_reg != 4'd15)
      round_cnt_next = round_cnt_reg + 4'd1;

    timeout_err_next = timeout_err_reg | ((state_reg == ST_RUN) && wd_fire && !abort);

    gap_cnt_next = (state_reg == ST_GAP && state_next == ST_GAP) ? gap_cnt_reg + 1'b1 : '0;
    wd_cnt_next  = (state_reg == ST_RUN && state_next == ST_RUN) ? wd_cnt_reg + 1'b1 : '0;

    if (state_reg == ST_RUN) begin
      rgb_next = slot_rgb[index_reg];
      x_next   = slot_x[index_reg];
      y_next   = slot_y[index_reg];
    end else begin
      rgb_next = rgb_in;
      x_next   = '0;
      y_next   = '0;
    end
  end

  // Registered outputs, counters and slot memory.
  always_ff @(posedge pclk) begin
    if (rst) begin
      index_reg       <= 2'd0;
      have_prev_reg   <= 1'b0;
      gap_cnt_reg     <= '0;
      wd_cnt_reg      <= '0;
      selected_reg    <= 4'b0000;
      start_reg       <= 1'b0;
      round_cnt_reg   <= 4'd0;
      all_done_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
      rgb_reg         <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
    end else begin
      index_reg       <= index_next;
      have_prev_reg   <= have_prev_reg | (state_reg == ST_PICK);
      gap_cnt_reg     <= gap_cnt_next;
      wd_cnt_reg      <= wd_cnt_next;
      selected_reg    <= selected_next;
      start_reg       <= start_next;
      round_cnt_reg   <= round_cnt_next;
      all_done_reg    <= all_done_next;
      timeout_err_reg <= timeout_err_next;
      rgb_reg         <= rgb_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
    end
  end

  assign selected    = selected_reg;
  assign start       = start_reg;
  assign rgb_out     = rgb_reg;
  assign obstacle_x  = x_reg;
  assign obstacle_y  = y_reg;
  assign round_cnt   = round_cnt_reg;
  assign all_done    = all_done_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomized bench for obstacle_scheduler with a transaction-level model:
// slot picks come from a software LFSR, timing from the documented latencies.
module tb_obstacle_scheduler;

  localparam int N_ROUNDS       = 3;
  localparam int GAP_CYCLES     = 10;
  localparam int TIMEOUT_CYCLES = 20;

  logic        pclk = 1'b0;
  logic        rst;
  logic        game_on, menu_on, play_selected;
  logic [3:0]  obst_done;
  logic [47:0] obst_rgb, obst_x, obst_y;
  logic [11:0] rgb_in;
  logic [3:0]  selected;
  logic        start;
  logic [11:0] rgb_out, obstacle_x, obstacle_y;
  logic [3:0]  round_cnt;
  logic        all_done, timeout_err;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0]  lfsr_m;
  int          prev_m;
  bit          have_prev_m;
  logic [11:0] m_rgb [4];
  logic [11:0] m_x [4];
  logic [11:0] m_y [4];

  obstacle_scheduler #(
    .N_ROUNDS(N_ROUNDS), .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .LFSR_SEED(8'hA5)
  ) dut (
    .pclk(pclk), .rst(rst), .game_on(game_on), .menu_on(menu_on),
    .play_selected(play_selected), .obst_done(obst_done), .obst_rgb(obst_rgb),
    .obst_x(obst_x), .obst_y(obst_y), .rgb_in(rgb_in), .selected(selected),
    .start(start), .rgb_out(rgb_out), .obstacle_x(obstacle_x),
    .obstacle_y(obstacle_y), .round_cnt(round_cnt), .all_done(all_done),
    .timeout_err(timeout_err)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Spec rule: x^8+x^6+x^5+x^4+1, advance then take the low two bits,
  // bumping by one (mod 4) if it would repeat the previous slot.
  function automatic int model_pick();
    int c;
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    c = int'(lfsr_m[1:0]);
    if (have_prev_m && c == prev_m) c = (c + 1) % 4;
    prev_m = c;
    have_prev_m = 1'b1;
    return c;
  endfunction

  task automatic new_slot_data();
    for (int i = 0; i < 4; i++) begin
      m_rgb[i] = 12'($urandom);
      m_x[i]   = 12'($urandom);
      m_y[i]   = 12'($urandom);
      obst_rgb[i*12 +: 12] = m_rgb[i];
      obst_x[i*12 +: 12]   = m_x[i];
      obst_y[i*12 +: 12]   = m_y[i];
    end
    rgb_in = 12'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_selected", selected, 0);
    check("rst_start_alldone", {start, all_done}, 0);
    check("rst_mux", {rgb_out, obstacle_x, obstacle_y}, 0);
    check("rst_round_cnt", round_cnt, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    lfsr_m = 8'hA5;
    have_prev_m = 1'b0;
    prev_m = 0;
  endtask

  // Qualifying inputs for one edge: IDLE -> PICK.
  task automatic begin_game();
    game_on = 1'b1; play_selected = 1'b1; menu_on = 1'b0;
    tick();
    game_on = 1'b0;
    check("pick_start_low", start, 0);
    check("pick_sel_zero", selected, 0);
  endtask

  // From PICK: one edge to selected, one more to the start pulse.
  task automatic pick_and_start(output int idx);
    idx = model_pick();
    tick();
    check("sel_before_start", selected, 48'(1 << idx));
    check("start_not_yet", start, 0);
    tick();
    check("start_pulse", start, 1);
    check("sel_at_start", selected, 48'(1 << idx));
    new_slot_data();
  endtask

  // d RUN cycles with ignored stray dones from other slots.
  task automatic run_body(input int idx, input int d);
    for (int k = 0; k < d; k++) begin
      obst_done = 4'($urandom) & ~(4'(1) << idx);
      tick();
      check("run_start_low", start, 0);
      check("run_sel_hold", selected, 48'(1 << idx));
      check("run_mux_rgb", rgb_out, m_rgb[idx]);
      check("run_mux_xy", {obstacle_x, obstacle_y}, {m_x[idx], m_y[idx]});
    end
    obst_done = 4'b0;
  endtask

  // Active slot's done, then the gap; ends at the edge that leaves GAP.
  task automatic finish_round(input int idx, input int round_no, input bit last);
    obst_done = 4'(1) << idx;
    tick();
    obst_done = 4'b0;
    check("done_sel_clear", selected, 0);
    check("done_round_cnt", round_cnt, 48'(round_no));
    check("done_mux_last_run", rgb_out, m_rgb[idx]);
    tick();
    check("gap_mux_rgb", rgb_out, rgb_in);
    check("gap_mux_xy", {obstacle_x, obstacle_y}, 0);
    for (int g = 2; g < GAP_CYCLES; g++) begin
      tick();
      check("gap_quiet", {start, all_done}, 0);
    end
    tick();
    if (last) begin
      check("all_done_pulse", all_done, 1);
      check("end_round_cnt", round_cnt, 48'(N_ROUNDS));
      check("end_sel_zero", selected, 0);
      tick();
      check("all_done_once", all_done, 0);
      check("idle_round_clear", round_cnt, 0);
      for (int k = 0; k < 4; k++) begin
        tick();
        check("idle_quiet", {selected, start, all_done}, 0);
      end
    end else begin
      check("gap_exit_no_all_done", all_done, 0);
      check("gap_exit_sel_zero", selected, 0);
    end
  endtask

  initial begin
    int idx, d;
    rst = 1'b1; game_on = 1'b0; menu_on = 1'b0; play_selected = 1'b0;
    obst_done = 4'b0; obst_rgb = '0; obst_x = '0; obst_y = '0; rgb_in = '0;
    tick();
    do_reset();

    // Game 1: full game with random done latencies.
    begin_game();
    for (int r = 1; r <= N_ROUNDS; r++) begin
      pick_and_start(idx);
      d = $urandom_range(0, 12);
      $display("game1 round=%0d slot=%0d run_cycles=%0d", r, idx, d + 1);
      run_body(idx, d);
      finish_round(idx, r, r == N_ROUNDS);
    end
    check("game1_no_timeout", timeout_err, 0);

    // Game 2: abort coincident with the active slot's done in round 2.
    begin_game();
    pick_and_start(idx);
    run_body(idx, $urandom_range(0, 5));
    finish_round(idx, 1, 1'b0);
    pick_and_start(idx);
    d = $urandom_range(0, 5);
    $display("game2 abort slot=%0d after_cycles=%0d", idx, d + 1);
    run_body(idx, d);
    menu_on = 1'b1;
    obst_done = 4'(1) << idx;
    tick();
    obst_done = 4'b0;
    check("abort_sel_clear", selected, 0);
    check("abort_no_all_done", {start, all_done}, 0);
    tick();
    check("abort_round_clear", round_cnt, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_idle_quiet", {selected, start, all_done}, 0);
    end
    menu_on = 1'b0;

    // Game 3: no done, watchdog fires after TIMEOUT_CYCLES RUN cycles.
    begin_game();
    pick_and_start(idx);
    $display("game3 timeout slot=%0d", idx);
    for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
      tick();
      check("wd_not_yet", timeout_err, 0);
      check("wd_sel_hold", selected, 48'(1 << idx));
    end
    tick();
    check("wd_fired", timeout_err, 1);
    check("wd_sel_clear", selected, 0);
    check("wd_round_cnt", round_cnt, 1);
    play_selected = 1'b0;
    tick();
    tick();
    check("wd_sticky", timeout_err, 1);
    check("wd_abort_idle", round_cnt, 0);

    // Game 4: reset in the middle of RUN, then the LFSR restarts from seed.
    begin_game();
    pick_and_start(idx);
    run_body(idx, 2);
    $display("game4 reset_in_run slot=%0d", idx);
    do_reset();
    begin_game();
    pick_and_start(idx);
    $display("game5 first_slot_after_reset=%0d", idx);
    menu_on = 1'b1;
    tick();
    check("final_abort_sel", selected, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Sequencer for the obstacle engines of the game screen. It picks the next obstacle pseudo-randomly and starts it with a one-cycle start pulse. It waits for that obstacle's `done`, inserts a rest gap, and repeats for a fixed number of rounds. It also muxes the active obstacle's pixel colour and hit coordinates onto a single bus for the draw chain and the collision logic.

## Interface
Parameters:
- `N_ROUNDS`, 8: obstacles run per game before `all_done`.
- `GAP_CYCLES`, 32000000: idle `pclk` cycles between obstacles.
- `TIMEOUT_CYCLES`, 2^30 - 1: watchdog limit on one obstacle run.
- `LFSR_SEED`, 8'hA5: LFSR value loaded at reset; must be non-zero.

Ports (one clock; reset is synchronous and active-high):
- `pclk`  in  1  pixel clock.
- `rst`  in  1  synchronous, active-high reset.
- `game_on`, `menu_on`, `play_selected`  in  1 each  game-mode flags.
- `obst_done`  in  4  per-slot `done` pulses; bit i belongs to slot i.
- `obst_rgb`  in  48  per-slot `rgb_out`; slot i occupies bits [12i+11:12i].
- `obst_x`, `obst_y`  in  48 each  per-slot hit coordinates, packed the same way.
- `rgb_in`  in  12  background pixel.
- `selected`  out  4  one-hot active slot; 4'b0000 when none.
- `start`  out  1  one-cycle pulse to the slots' `done_in` inputs.
- `rgb_out`  out  12  muxed pixel.
- `obstacle_x`, `obstacle_y`  out  12 each  muxed hit coordinates.
- `round_cnt`  out  4  rounds completed.
- `all_done`  out  1  one-cycle pulse when the game completes.
- `timeout_err`  out  1  sticky flag, set when the watchdog fires.

## Operation
- States are IDLE, PICK, START, RUN and GAP.
- IDLE:
  - `selected` = 0 and the round counter is cleared.
  - Leave for PICK when `game_on && play_selected && !menu_on`.
- PICK:
  - Advance the LFSR once. It is 8-bit with taps 8,6,5,4 (x^8+x^6+x^5+x^4+1).
  - Candidate index = `lfsr[1:0]`. If the candidate equals the previous index, use (candidate+1) mod 4 instead, so the same slot never runs twice in a row.
  - Register the index, drive `selected` = 1<<index, then go to START.
- START: `start` = 1 for exactly this cycle, then go to RUN.
- RUN:
  - Leave for GAP when `obst_done[index]` = 1, and increment `round_cnt`.
  - Leave for GAP when the watchdog reaches `TIMEOUT_CYCLES`. This also sets `timeout_err` and counts as a completed round.
  - Done pulses from non-active slots are ignored.
- GAP:
  - Count `GAP_CYCLES`. When `round_cnt == N_ROUNDS`, pulse `all_done` and go to IDLE; otherwise go to PICK.
- Abort: `menu_on` or `!play_selected` in any non-IDLE state sends the FSM to IDLE on the next edge. This overrides a simultaneous done or timeout in the same cycle, and no `all_done` is issued.
- Mux behaviour:
  - In RUN: `rgb_out` = slot[index] rgb, `obstacle_x`/`obstacle_y` = slot[index] coordinates.
  - Otherwise: `rgb_out` = `rgb_in`, coordinates = 0.
- Width rules:
  - The gap and watchdog counters are 30-bit and restart from 0 on every state entry.
  - `round_cnt` saturates at 15.

## Timing
- Reset values: `selected` = 0, `start` = 0, `rgb_out` = 0, `obstacle_x` = 0, `obstacle_y` = 0, `round_cnt` = 0, `all_done` = 0, `timeout_err` = 0, state = IDLE, LFSR = `LFSR_SEED`.
- Reset mid-run behaves identically to the reset state above.
- All outputs are registered.
- Mux latency is 1 `pclk`. With the obstacle engine's own 1-cycle latency, the downstream hsync/vsync/blank delay must total 2 cycles.
- `selected` is valid in the cycle before `start` rises and holds stable until the FSM leaves RUN. Slots sample both signals in their IDLE state.
- Start-up latency: IDLE qualifying inputs → `start` high after 3 edges (IDLE→PICK, PICK→START, `start` registered).
- Done path: `obst_done` sampled high → `selected` cleared to 0 at the next edge.
- End of game: `all_done` is asserted on the edge that leaves GAP for IDLE, for 1 cycle.
- `timeout_err` clears only on `rst`.

## Structure
- Shared package `obstacle_pkg` holds:
  - `N_OBST` = 4.
  - Slot one-hot codes, matching the slot decode: 4'b0001, 4'b0010 (horizontal lasers), 4'b0100, 4'b1000.
  - The state encoding localparams.
- One sub-module `obstacle_lfsr` (8-bit, enable, seed parameter).
- FSM, counters and mux live in the top module.

## Test plan
- Reset, then `game_on=1, play_selected=1, menu_on=0` → `start` pulses exactly once, 3 cycles later, and `selected` is one-hot and stable from the cycle before the pulse through RUN.
- Active slot pulses done with `GAP_CYCLES=10` → `selected`=0 next edge, `round_cnt` increments, next `start` follows 10 gap cycles + 2 cycles later, and the new slot differs from the previous one.
- `N_ROUNDS=3` with immediate dones → exactly 3 starts, `round_cnt`=3, one `all_done` pulse, FSM back in IDLE with `selected`=0.
- In RUN, drive slot 2 rgb=12'h0F0 and `rgb_in`=12'h111 → `rgb_out` = the active slot's colour 1 cycle later; in GAP `rgb_out`=12'h111 and coordinates = 0.
- Assert `menu_on` in the same cycle as the active slot's done → IDLE next edge, no `all_done`, `round_cnt` cleared.
- `TIMEOUT_CYCLES=20` with no done → `timeout_err`=1 after 20 RUN cycles, FSM enters GAP; the flag stays set until `rst`.
